sdr_wb_arb: RTL

- Two-master Wishbone arbiter in front of the single WB slave port of `sdrc_top`.
- Lets a CPU-side master (m0) and a DMA-side master (m1) share the SDRAM controller.
- Round-robin fairness with grant held for a whole WB cycle, so incrementing bursts stay intact.
- Grants held off until `sdr_init_done`; per-transfer ack timeout returns an error and frees the bus.

---
 rtl/sdr_wb_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sdr_wb_arb.sv
// sdr_wb_arb: two-master round-robin Wishbone arbiter in front of the sdrc_top slave port.
// Rev 1.0 - initial release.
`default_nettype none

module sdr_wb_arb #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int TMO_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sdram_resetn,
  input  logic              sdr_init_done,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [APP_AW-1:0] m0_addr_i,
  input  logic [dw-1:0]     m0_dat_i,
  input  logic [dw/8-1:0]   m0_sel_i,
  input  logic [2:0]        m0_cti_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [dw-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [APP_AW-1:0] m1_addr_i,
  input  logic [dw-1:0]     m1_dat_i,
  input  logic [dw/8-1:0]   m1_sel_i,
  input  logic [2:0]        m1_cti_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [dw-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [APP_AW-1:0] s_addr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [dw/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic              s_ack_i,
  input  logic [dw-1:0]     s_dat_i,

  output logic [1:0]        gnt_o
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    RECOV = 2'd3
  } state_t;

  state_t           state_q;
  logic             lst_q;
  logic [TMO_W-1:0] tmo_q;

  logic g0;
  logic g1;
  logic tmo_fire;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  // Slave-side muxing depends only on state and master inputs, never on s_ack_i.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    if (g0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cti_o  = m0_cti_i;
    end else if (g1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cti_o  = m1_cti_i;
    end
  end

  // A real ack in the same cycle as the last timeout count wins over the error.
  assign tmo_fire = (g0 || g1) && s_stb_o && !s_ack_i && (tmo_q == TMO_MAX);

  assign m0_ack_o = g0 && s_ack_i;
  assign m1_ack_o = g1 && s_ack_i;
  assign m0_err_o = g0 && tmo_fire;
  assign m1_err_o = g1 && tmo_fire;
  assign m0_dat_o = (g0 || g1) ? s_dat_i : '0;
  assign m1_dat_o = (g0 || g1) ? s_dat_i : '0;
  assign gnt_o    = {g1, g0};

  always_ff @(posedge sys_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= IDLE;
      lst_q   <= 1'b1;
      tmo_q   <= '0;
    end else begin
      if (s_ack_i || !s_stb_o) begin
        tmo_q <= '0;
      end else if (g0 || g1) begin
        tmo_q <= tmo_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (sdr_init_done) begin
            if (m0_cyc_i && (!m1_cyc_i || lst_q)) begin
              state_q <= GNT0;
            end else if (m1_cyc_i) begin
              state_q <= GNT1;
            end
          end
        end
        GNT0: begin
          if (tmo_fire) begin
            state_q <= RECOV;
            lst_q   <= 1'b0;
            tmo_q   <= '0;
          end else if (!m0_cyc_i) begin
            state_q <= IDLE;
            lst_q   <= 1'b0;
          end
        end
        GNT1: begin
          if (tmo_fire) begin
            state_q <= RECOV;
            lst_q   <= 1'b1;
            tmo_q   <= '0;
          end else if (!m1_cyc_i) begin
            state_q <= IDLE;
            lst_q   <= 1'b1;
          end
        end
        RECOV:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
